// File: rtl/ttlx8_pkg.sv
// ttlx8_pkg: shared constants and types for the ttlx8_event_decoder slice.
//   - Channel count, sub-samples per clock and pulse-width field width.
//   - Bit positions of the command fields inside rto_out[63:0].
//   - ttl_cmd_t (decoded command) and ttl_ch_state_e (per-channel pulse state).
//   - pulse_end(): absolute end sub-sample e = fine + width.
package ttlx8_pkg;

    localparam int NUM_CH    = 8;
    localparam int SUB       = 4;
    localparam int WIDTH_LEN = 16;
    localparam int CNT_W     = WIDTH_LEN + 2;
    localparam int CMD_W     = 64;

    localparam int MASK_LSB  = 0;
    localparam int LEVEL_LSB = 8;
    localparam int FINE_LSB  = 16;
    localparam int PULSE_BIT = 18;
    localparam int WIDTH_LSB = 24;

    typedef struct packed {
        logic [WIDTH_LEN-1:0] width;
        logic                 pulse;
        logic [1:0]           fine;
        logic [NUM_CH-1:0]    level;
        logic [NUM_CH-1:0]    mask;
    } ttl_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } ttl_ch_state_e;

    // End sub-sample counted from sub-sample 0 of the event word; wide enough
    // that fine + max width never wraps.
    function automatic logic [CNT_W-1:0] pulse_end(input logic [1:0]           fine,
                                                   input logic [WIDTH_LEN-1:0] width);
        return {2'b00, width} + {{(CNT_W-2){1'b0}}, fine};
    endfunction

endpackage

// File: rtl/ttlx8_event_decoder_if.sv
// ttlx8_event_decoder_if: event input and TTL output bundle of the decoder.
//   master: RTO core / test side (drives counter_matched, rto_out, clear_error)
//   slave : the decoder (drives ttl_word, ttl_level, pulse_busy,
//           collision_error, error_data)
interface ttlx8_event_decoder_if;
    import ttlx8_pkg::*;

    logic                    counter_matched;
    logic [127:0]            rto_out;
    logic                    clear_error;
    logic [NUM_CH*SUB-1:0]   ttl_word;
    logic [NUM_CH-1:0]       ttl_level;
    logic [NUM_CH-1:0]       pulse_busy;
    logic                    collision_error;
    logic [CMD_W-1:0]        error_data;

    modport master (
        output counter_matched, rto_out, clear_error,
        input  ttl_word, ttl_level, pulse_busy, collision_error, error_data
    );

    modport slave (
        input  counter_matched, rto_out, clear_error,
        output ttl_word, ttl_level, pulse_busy, collision_error, error_data
    );

endinterface

// File: rtl/ttl_channel_pulse.sv
// ttl_channel_pulse: one TTL channel. Holds the channel level, the pulse
// state and the word countdown, and produces the registered 4-sub-sample word.
//   clk, resetn   : rtio_clk, async active-low reset
//   i_evt         : masked event for this channel this cycle
//   i_level       : new level (pulse level in pulse mode)
//   i_fine        : first sub-sample at which the event takes effect
//   i_pulse       : pulse mode with width >= 1
//   i_width       : pulse width in sub-samples
//   o_word        : registered sub-sample bits, bit 0 earliest
//   o_busy        : registered, a pulse end is pending or emitted this word
//   o_collision   : combinational, event arrives while a pulse is pending
module ttl_channel_pulse
    import ttlx8_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_evt,
    input  logic                 i_level,
    input  logic [1:0]           i_fine,
    input  logic                 i_pulse,
    input  logic [WIDTH_LEN-1:0] i_width,
    output logic [SUB-1:0]       o_word,
    output logic                 o_busy,
    output logic                 o_collision
);

    ttl_ch_state_e    r_state;
    ttl_ch_state_e    w_state_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_end_sub;
    logic [1:0]       w_end_sub_nxt;
    logic [SUB-1:0]   r_word;
    logic [SUB-1:0]   w_word_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             w_end_now;
    logic [CNT_W-1:0] w_e;
    logic [SUB-1:0]   w_old;

    // Next word, next level and pulse-state transitions for this channel.
    always_comb begin
        w_e           = pulse_end(i_fine, i_width);
        w_end_now     = (r_state == PEND) && (r_cnt == {CNT_W{1'b0}});
        w_old         = {SUB{1'b0}};
        w_state_nxt   = r_state;
        w_level_nxt   = r_level;
        w_cnt_nxt     = r_cnt;
        w_end_sub_nxt = r_end_sub;
        w_busy_nxt    = 1'b0;

        // Word the channel would emit with no event: in the end word the
        // pulse level holds until the end sub-sample, then inverts.
        for (int k = 0; k < SUB; k++) begin
            if (w_end_now && (2'(k) >= r_end_sub)) begin
                w_old[k] = ~r_level;
            end else begin
                w_old[k] = r_level;
            end
        end
        w_word_nxt = w_old;

        if (i_evt) begin
            // Sub-samples before fine keep the old behaviour (including a
            // pending end landing in this word); the new event owns the rest.
            for (int k = 0; k < SUB; k++) begin
                if (2'(k) < i_fine) begin
                    w_word_nxt[k] = w_old[k];
                end else if (i_pulse && (CNT_W'(k) >= w_e)) begin
                    w_word_nxt[k] = ~i_level;
                end else begin
                    w_word_nxt[k] = i_level;
                end
            end
            if (!i_pulse) begin
                w_state_nxt = IDLE;
                w_level_nxt = i_level;
            end else if (w_e < CNT_W'(SUB)) begin
                // Whole pulse fits in the event word.
                w_state_nxt = IDLE;
                w_level_nxt = ~i_level;
            end else begin
                // Countdown reaches zero on the cycle that emits the end word.
                w_state_nxt   = PEND;
                w_level_nxt   = i_level;
                w_cnt_nxt     = {2'b00, w_e[CNT_W-1:2]} - {{(CNT_W-1){1'b0}}, 1'b1};
                w_end_sub_nxt = w_e[1:0];
                w_busy_nxt    = 1'b1;
            end
        end else if (r_state == PEND) begin
            w_busy_nxt = 1'b1;
            if (w_end_now) begin
                w_state_nxt = IDLE;
                w_level_nxt = ~r_level;
            end else begin
                w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            w_busy_nxt = 1'b0;
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_level   <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_end_sub <= 2'b00;
            r_word    <= {SUB{1'b0}};
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_level   <= w_level_nxt;
            r_cnt     <= w_cnt_nxt;
            r_end_sub <= w_end_sub_nxt;
            r_word    <= w_word_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign o_word      = r_word;
    assign o_busy      = r_busy;
    assign o_collision = i_evt && (r_state == PEND);

endmodule

// File: rtl/ttlx8_event_decoder.sv
// ttlx8_event_decoder: turns RTO events into per-cycle 4-sub-sample words for
// eight TTL channels, with optional hardware-timed pulses.
//   clk    : rtio_clk
//   resetn : async active-low reset, clears every output
//   bus    : ttlx8_event_decoder_if.slave
//            in : counter_matched, rto_out[127:0] (only [63:0] used), clear_error
//            out: ttl_word, ttl_level, pulse_busy, collision_error, error_data
// Build option TTLX8_PULSE_MODE_EN: when defined, pulse mode, pulse_busy and
// collision detection are present; otherwise every event is a level-set and
// pulse_busy / collision_error / error_data are held at 0.
module ttlx8_event_decoder
    import ttlx8_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    ttlx8_event_decoder_if.slave  bus
);

    ttl_cmd_t              w_cmd;
    logic                  w_pulse;
    logic [NUM_CH*SUB-1:0] w_word;
    logic [NUM_CH-1:0]     w_busy;
    logic [NUM_CH-1:0]     w_coll;
    logic [NUM_CH-1:0]     w_level;

    assign w_cmd.mask  = bus.rto_out[MASK_LSB  +: NUM_CH];
    assign w_cmd.level = bus.rto_out[LEVEL_LSB +: NUM_CH];
    assign w_cmd.fine  = bus.rto_out[FINE_LSB  +: 2];
    assign w_cmd.pulse = bus.rto_out[PULSE_BIT];
    assign w_cmd.width = bus.rto_out[WIDTH_LSB +: WIDTH_LEN];

`ifdef TTLX8_PULSE_MODE_EN
    // A zero-width pulse degenerates to a level-set.
    assign w_pulse = w_cmd.pulse && (w_cmd.width != {WIDTH_LEN{1'b0}});
`else
    assign w_pulse = 1'b0;
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        ttl_channel_pulse u_ch (
            .clk         (clk),
            .resetn      (resetn),
            .i_evt       (bus.counter_matched && w_cmd.mask[ch]),
            .i_level     (w_cmd.level[ch]),
            .i_fine      (w_cmd.fine),
            .i_pulse     (w_pulse),
            .i_width     (w_cmd.width),
            .o_word      (w_word[ch*SUB +: SUB]),
            .o_busy      (w_busy[ch]),
            .o_collision (w_coll[ch])
        );
    end

    // Level at the last sub-sample of each channel's current word.
    always_comb begin
        w_level = {NUM_CH{1'b0}};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_level[ch] = w_word[ch*SUB + SUB - 1];
        end
    end

    assign bus.ttl_word  = w_word;
    assign bus.ttl_level = w_level;

`ifdef TTLX8_PULSE_MODE_EN
    logic             r_err;
    logic [CMD_W-1:0] r_err_data;
    logic             w_unused_rto;

    // Sticky collision flag; the command is captured when the flag is clear,
    // or recaptured when a clear coincides with a new collision.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err      <= 1'b0;
            r_err_data <= {CMD_W{1'b0}};
        end else if (|w_coll) begin
            r_err <= 1'b1;
            if (!r_err || bus.clear_error) begin
                r_err_data <= bus.rto_out[CMD_W-1:0];
            end else begin
                r_err_data <= r_err_data;
            end
        end else if (bus.clear_error) begin
            r_err      <= 1'b0;
            r_err_data <= r_err_data;
        end else begin
            r_err      <= r_err;
            r_err_data <= r_err_data;
        end
    end

    assign bus.pulse_busy      = w_busy;
    assign bus.collision_error = r_err;
    assign bus.error_data      = r_err_data;
    assign w_unused_rto        = ^bus.rto_out[127:64];
`else
    logic w_unused_cfg;

    assign bus.pulse_busy      = {NUM_CH{1'b0}};
    assign bus.collision_error = 1'b0;
    assign bus.error_data      = {CMD_W{1'b0}};
    assign w_unused_cfg        = ^{bus.rto_out[127:40], bus.rto_out[23:19], w_cmd.pulse,
                                   bus.clear_error, w_coll, w_busy};
`endif

endmodule

// File: tb/tb_ttlx8_event_decoder.sv
// Self-checking bench for ttlx8_event_decoder. A sub-sample timeline model
// predicts every output each cycle; directed events with literal expectations
// pin the model.
module tb_ttlx8_event_decoder;

`ifdef TTLX8_PULSE_MODE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    ttlx8_event_decoder_if bus ();

    ttlx8_event_decoder dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- model: absolute sub-sample timeline ----------------
    int          m_w;            // word index since reset
    bit          m_cur  [8];     // channel level at the latest sub-sample
    bit          m_pv   [8];     // a pulse end is scheduled
    int          m_pt   [8];     // absolute sub-sample of that end
    bit          m_pval [8];     // level after the end
    bit          m_rv   [8];     // multi-word pulse record valid
    int          m_re   [8];     // word index holding the pulse end
    logic [31:0] exp_word;
    logic [7:0]  exp_busy;
    logic [7:0]  exp_level;
    logic        exp_err;
    logic [63:0] exp_data;

    logic        s_cm;
    logic [63:0] s_cmd;
    logic        s_clr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_w = 0;
        for (int ch = 0; ch < 8; ch++) begin
            m_cur[ch] = 1'b0; m_pv[ch] = 1'b0; m_pt[ch] = 0;
            m_pval[ch] = 1'b0; m_rv[ch] = 1'b0; m_re[ch] = 0;
        end
        exp_word = '0; exp_busy = '0; exp_level = '0; exp_err = 1'b0; exp_data = '0;
    endtask

    task automatic model_step(input logic cm, input logic [63:0] c, input logic clr);
        bit coll;
        bit ev;
        int f;
        int wd;
        int t;
        coll = 1'b0;
        f  = int'(c[17:16]);
        wd = int'(c[39:24]);
        for (int ch = 0; ch < 8; ch++) begin
            ev = cm && c[ch];
            if (ev && m_rv[ch] && (m_w <= m_re[ch])) coll = 1'b1;
            if (ev) m_rv[ch] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                t = 4 * m_w + k;
                if (m_pv[ch] && (m_pt[ch] == t)) begin
                    m_cur[ch] = m_pval[ch];
                    m_pv[ch]  = 1'b0;
                end
                if (ev && (k == f)) begin
                    m_pv[ch]  = 1'b0;
                    m_cur[ch] = c[8 + ch];
                    if (PEN && c[18] && (wd != 0)) begin
                        m_pt[ch]   = t + wd;
                        m_pval[ch] = !c[8 + ch];
                        m_pv[ch]   = 1'b1;
                        if (m_pt[ch] / 4 > m_w) begin
                            m_rv[ch] = 1'b1;
                            m_re[ch] = m_pt[ch] / 4;
                        end
                    end
                end
                exp_word[ch*4 + k] = m_cur[ch];
            end
            exp_level[ch] = m_cur[ch];
            exp_busy[ch]  = m_rv[ch] && (m_w <= m_re[ch]);
        end
        if (coll) begin
            if (!exp_err || clr) exp_data = c;
            exp_err = 1'b1;
        end else if (clr) begin
            exp_err = 1'b0;
        end
        m_w++;
    endtask

    // Advance the model on every edge and compare all outputs just after it.
    always @(posedge clk) begin
        s_cm  = bus.counter_matched;
        s_cmd = bus.rto_out[63:0];
        s_clr = bus.clear_error;
        if (!resetn) model_reset();
        else         model_step(s_cm, s_cmd, s_clr);
        #1;
        chk("model word",  {32'h0, bus.ttl_word},   {32'h0, exp_word});
        chk("model level", {56'h0, bus.ttl_level},  {56'h0, exp_level});
        chk("model busy",  {56'h0, bus.pulse_busy}, {56'h0, exp_busy});
        chk("model err",   {63'h0, bus.collision_error}, {63'h0, exp_err});
        chk("model data",  bus.error_data, exp_data);
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [63:0] mk(input logic [7:0] m, input logic [7:0] l,
                                       input logic [1:0] f, input logic p,
                                       input logic [15:0] wd);
        return {24'h5A3C96, wd, 5'b10101, p, f, l, m};
    endfunction

    // Called at a negedge; event sampled at the next posedge, returns at the
    // following negedge when the event word is on ttl_word.
    task automatic send(input logic [63:0] cmd);
        bus.counter_matched = 1'b1;
        bus.rto_out         = {64'hFEED_F00D_0BAD_CAFE, cmd};
        @(negedge clk);
        bus.counter_matched = 1'b0;
        bus.rto_out         = {64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF};
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    logic [63:0] c2;
    logic [63:0] c3;
    logic [3:0]  lp_word [5];
    logic        lp_busy [5];

    initial begin
        resetn              = 1'b0;
        bus.counter_matched = 1'b0;
        bus.clear_error     = 1'b0;
        bus.rto_out         = {64'hDEAD_BEEF_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF};
        repeat (2) @(negedge clk);
        chk("reset word", {32'h0, bus.ttl_word}, 64'h0);
        chk("reset busy", {56'h0, bus.pulse_busy}, 64'h0);
        chk("reset err",  {63'h0, bus.collision_error}, 64'h0);
        chk("reset data", bus.error_data, 64'h0);
        resetn = 1'b1;
        repeat (3) nxt();
        chk("idle word", {32'h0, bus.ttl_word}, 64'h0);

        // level-set ch0, f=2
        send(mk(8'h01, 8'h01, 2'd2, 1'b0, 16'd0));
        chk("ls event word", {60'h0, bus.ttl_word[3:0]}, 64'hC);
        nxt();
        chk("ls next word", {60'h0, bus.ttl_word[3:0]}, 64'hF);
        chk("ls level", {63'h0, bus.ttl_level[0]}, 64'h1);

        // short pulse ch7, f=1, W=2
        send(mk(8'h80, 8'h80, 2'd1, 1'b1, 16'd2));
        chk("short word", {60'h0, bus.ttl_word[31:28]}, PEN ? 64'h6 : 64'hE);
        chk("short busy", {63'h0, bus.pulse_busy[7]}, 64'h0);
        nxt();
        chk("short after", {60'h0, bus.ttl_word[31:28]}, PEN ? 64'h0 : 64'hF);

        // long pulse ch3, f=3, W=10
        lp_word = PEN ? '{4'h8, 4'hF, 4'hF, 4'h1, 4'h0} : '{4'h8, 4'hF, 4'hF, 4'hF, 4'hF};
        lp_busy = PEN ? '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0} : '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send(mk(8'h08, 8'h08, 2'd3, 1'b1, 16'd10));
        for (int i = 0; i < 5; i++) begin
            chk("long word", {60'h0, bus.ttl_word[15:12]}, {60'h0, lp_word[i]});
            chk("long busy", {63'h0, bus.pulse_busy[3]}, {63'h0, lp_busy[i]});
            nxt();
        end

        // collision: ch1 pulse W=40, level-set 3 cycles later
        send(mk(8'h02, 8'h02, 2'd0, 1'b1, 16'd40));
        nxt();
        nxt();
        c2 = mk(8'h02, 8'h00, 2'd0, 1'b0, 16'd0);
        send(c2);
        chk("coll word", {60'h0, bus.ttl_word[7:4]}, 64'h0);
        chk("coll flag", {63'h0, bus.collision_error}, PEN ? 64'h1 : 64'h0);
        chk("coll data", bus.error_data, PEN ? c2 : 64'h0);
        bus.clear_error = 1'b1;
        nxt();
        bus.clear_error = 1'b0;
        chk("clear flag", {63'h0, bus.collision_error}, 64'h0);

        // e=4 boundary on ch4
        send(mk(8'h10, 8'h10, 2'd0, 1'b1, 16'd4));
        nxt();
        nxt();

        // collision landing in the end word (end sub-sample 2, new fine 3)
        send(mk(8'h20, 8'h20, 2'd0, 1'b1, 16'd6));
        send(mk(8'h20, 8'h00, 2'd3, 1'b0, 16'd0));
        chk("endword coll", {60'h0, bus.ttl_word[23:20]}, PEN ? 64'h3 : 64'h7);
        nxt();

        // clear_error together with a new collision: data recaptured
        send(mk(8'h04, 8'h04, 2'd1, 1'b1, 16'd100));
        nxt();
        c3 = mk(8'h04, 8'h00, 2'd2, 1'b0, 16'd0);
        bus.clear_error = 1'b1;
        send(c3);
        bus.clear_error = 1'b0;
        chk("clr+coll flag", {63'h0, bus.collision_error}, PEN ? 64'h1 : 64'h0);
        chk("clr+coll data", bus.error_data, PEN ? c3 : 64'h0);
        // second collision with the flag set keeps the first command
        send(mk(8'h04, 8'h04, 2'd0, 1'b1, 16'd50));
        nxt();
        send(mk(8'h04, 8'h04, 2'd0, 1'b1, 16'd8));
        chk("sticky data", bus.error_data, PEN ? c3 : 64'h0);

        // back-to-back multi-channel events incl. maximum width
        send(mk(8'hFF, 8'hAA, 2'd1, 1'b1, 16'd3));
        send(mk(8'h0F, 8'h05, 2'd2, 1'b0, 16'd0));
        send(mk(8'hF0, 8'hF0, 2'd3, 1'b1, 16'hFFFF));
        repeat (3) nxt();
        send(mk(8'hF0, 8'h00, 2'd0, 1'b0, 16'd0));
        repeat (6) nxt();

        // reset in the middle of a pulse
        send(mk(8'h20, 8'h20, 2'd0, 1'b1, 16'd200));
        nxt();
        #2 resetn = 1'b0;
        #1;
        chk("midrst word",  {32'h0, bus.ttl_word}, 64'h0);
        chk("midrst busy",  {56'h0, bus.pulse_busy}, 64'h0);
        chk("midrst level", {56'h0, bus.ttl_level}, 64'h0);
        chk("midrst err",   {63'h0, bus.collision_error}, 64'h0);
        chk("midrst data",  bus.error_data, 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) nxt();
        chk("post rst word", {32'h0, bus.ttl_word}, 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
